// File: rtl/dbn_pkg.sv
// Shared definitions for the DBN address-generation path: phase codes,
// unit count, address width and FIFO depth, plus the phase decoder.
package dbn_pkg;

  // Global phase codes driven by the top-level controller.
  typedef enum logic [2:0] {
    PH_IDLE    = 3'b000,
    PH_LOAD    = 3'b001,
    PH_FETCH_V = 3'b010,
    PH_FETCH_H = 3'b011,
    PH_DONE    = 3'b100,
    PH_GEN_V   = 3'b101,
    PH_GEN_H   = 3'b111
  } phase_e;

  localparam int NUM_UNITS  = 3;  // units per layer scanned in a GEN phase
  localparam int ADDR_W     = 2;  // weight-memory row address width
  localparam int FIFO_DEPTH = 4;  // address FIFO entries
  localparam int SCAN_W     = 2;  // scan index width (0..NUM_UNITS)

  // Map the raw 3-bit code onto a phase; the reserved code 110 acts as IDLE.
  function automatic phase_e decode_phase(input logic [2:0] code);
    phase_e ph;
    case (code)
      3'b000:  ph = PH_IDLE;
      3'b001:  ph = PH_LOAD;
      3'b010:  ph = PH_FETCH_V;
      3'b011:  ph = PH_FETCH_H;
      3'b100:  ph = PH_DONE;
      3'b101:  ph = PH_GEN_V;
      3'b111:  ph = PH_GEN_H;
      default: ph = PH_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/addr_fifo.sv
// First-word-fall-through FIFO with synchronous clear. A clear may coincide
// with a push: the FIFO is emptied and the pushed word becomes the only entry.
module addr_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_addr_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic             empty_s;
  logic             full_s;

  // Advance a pointer with wrap at DEPTH-1 (works for any depth).
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  assign empty_s = (count_q == CNT_W'(0));
  assign full_s  = (count_q == CNT_W'(DEPTH));

  // Next-state for pointers and count; clear takes priority over normal flow.
  always_comb begin
    do_push_s = push_i && (clear_i || !full_s);
    do_pop_s  = pop_i && !empty_s && !clear_i;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_addr_s = wr_ptr_q;
    if (clear_i) begin
      wr_addr_s = '0;
      rd_ptr_d  = '0;
      if (do_push_s) begin
        wr_ptr_d = next_ptr('0);
        count_d  = CNT_W'(1);
      end else begin
        wr_ptr_d = '0;
        count_d  = '0;
      end
    end else begin
      if (do_push_s) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are masked by the empty flag so need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_addr_s] <= push_data_i;
    end
  end

  // Head word falls through; reads as zero while empty.
  always_comb begin
    if (empty_s) begin
      head_o = '0;
    end else begin
      head_o = mem_q[rd_ptr_q];
    end
  end

  assign count_o = count_q;
  assign empty_o = empty_s;
  assign full_o  = full_s;

endmodule

// File: rtl/addr_gen.sv
// Address generator: scans visible/hidden unit states during GEN phases,
// queues the indices of active units, and hands them out during FETCH phases.
module addr_gen
  import dbn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        statesignal,
  input  logic [NUM_UNITS-1:0] v_states,
  input  logic [NUM_UNITS-1:0] h_states,
  input  logic              en_fetch,
  output logic [ADDR_W-1:0] addr_fetch,
  output logic              empty_fifo
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [SCAN_W-1:0] SCAN_DONE = SCAN_W'(NUM_UNITS);

  phase_e              prev_q, prev_d;
  logic [SCAN_W-1:0]   idx_q, idx_d;
  phase_e              phase_s;
  logic                is_gen_s;
  logic                is_fetch_s;
  logic                gen_entry_s;
  logic [NUM_UNITS-1:0] scan_bits_s;
  logic [SCAN_W-1:0]   scan_idx_s;
  logic                push_s;
  logic                pop_s;
  logic                clear_s;
  logic [ADDR_W-1:0]   fifo_head_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic                fifo_empty_s;
  logic                fifo_full_s;

  assign phase_s     = decode_phase(statesignal);
  assign is_gen_s    = (phase_s == PH_GEN_V) || (phase_s == PH_GEN_H);
  assign is_fetch_s  = (phase_s == PH_FETCH_V) || (phase_s == PH_FETCH_H);
  assign gen_entry_s = en && is_gen_s && (phase_s != prev_q);
  assign scan_bits_s = (phase_s == PH_GEN_H) ? h_states : v_states;

  // Scan and push/pop control; a GEN entry restarts the scan at index 0 and
  // examines that index in the same cycle as the clear.
  always_comb begin
    prev_d     = prev_q;
    idx_d      = idx_q;
    scan_idx_s = idx_q;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    clear_s    = 1'b0;
    if (en) begin
      prev_d = phase_s;
      if (is_gen_s) begin
        if (gen_entry_s) begin
          clear_s    = 1'b1;
          scan_idx_s = '0;
        end else begin
          scan_idx_s = idx_q;
        end
        if (scan_idx_s < SCAN_DONE) begin
          push_s = scan_bits_s[scan_idx_s] && (clear_s || !fifo_full_s);
          idx_d  = scan_idx_s + SCAN_W'(1);
        end else begin
          idx_d  = SCAN_DONE;
        end
      end else if (is_fetch_s) begin
        pop_s = en_fetch && !fifo_empty_s;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      prev_d = prev_q;
    end
  end

  // Phase history and scan index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= PH_IDLE;
      idx_q  <= '0;
    end else begin
      prev_q <= prev_d;
      idx_q  <= idx_d;
    end
  end

  addr_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clear_i     (clear_s),
    .push_i      (push_s),
    .push_data_i (ADDR_W'(scan_idx_s)),
    .pop_i       (pop_s),
    .head_o      (fifo_head_s),
    .count_o     (fifo_count_s),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s)
  );

  assign addr_fetch = fifo_head_s;
  assign empty_fifo = (fifo_count_s == CNT_W'(0));

endmodule

// File: tb/tb_addr_gen.sv
// Self-checking bench for addr_gen: directed scenarios followed by random
// phase/enable/state traffic, all checked against a queue-based model.
module tb_addr_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] statesignal;
  logic [2:0] v_states;
  logic [2:0] h_states;
  logic       en_fetch;
  logic [1:0] addr_fetch;
  logic       empty_fifo;

  int checks;
  int failures;

  // Reference model state
  int m_q[$];
  int m_prev;
  int m_idx;

  addr_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .statesignal (statesignal),
    .v_states    (v_states),
    .h_states    (h_states),
    .en_fetch    (en_fetch),
    .addr_fetch  (addr_fetch),
    .empty_fifo  (empty_fifo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dec(input logic [2:0] c);
    if (c == 3'b110) return 0;
    return int'(c);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_prev = 0;
    m_idx  = 0;
  endtask

  // One clock of the model, using the inputs currently applied.
  task automatic model_step();
    int ph;
    logic [2:0] bits;
    if (en) begin
      ph = dec(statesignal);
      if (ph == 5 || ph == 7) begin
        bits = (ph == 7) ? h_states : v_states;
        if (ph != m_prev) begin
          m_q.delete();
          m_idx = 0;
        end
        if (m_idx < 3) begin
          if (bits[m_idx] && m_q.size() < 4) m_q.push_back(m_idx);
          m_idx++;
        end
      end else if (ph == 2 || ph == 3) begin
        if (en_fetch && m_q.size() > 0) void'(m_q.pop_front());
      end
      m_prev = ph;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int ea;
    logic [1:0] ea2;
    ea  = (m_q.size() > 0) ? m_q[0] : 0;
    ea2 = ea[1:0];
    chk({tag, ".addr"}, addr_fetch, ea2);
    chk({tag, ".empty"}, {1'b0, empty_fifo}, {1'b0, (m_q.size() == 0)});
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic [2:0] ss, input logic e, input logic ef);
    statesignal = ss;
    en          = e;
    en_fetch    = ef;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    en = 1'b0;
    statesignal = 3'b000;
    v_states = 3'b000;
    h_states = 3'b000;
    en_fetch = 1'b0;
    model_reset();
    #2;
    chk("reset.addr", addr_fetch, 2'b00);
    chk("reset.empty", {1'b0, empty_fifo}, 2'b01);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_model("post_reset");

    // GEN_V with v=101 for 3 cycles -> {0,2}
    v_states = 3'b101;
    drive(3'b101, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick("genv_101");
    chk("genv_101.head", addr_fetch, 2'b00);
    chk("genv_101.nonempty", {1'b0, empty_fifo}, 2'b00);

    // FETCH_V draining with en_fetch = !empty
    drive(3'b010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      en_fetch = ~empty_fifo;
      tick("fetchv");
      if (i == 0) chk("fetchv.second", addr_fetch, 2'b10);
    end
    chk("fetchv.drained", {1'b0, empty_fifo}, 2'b01);

    // GEN_H with h=110 then FETCH_H -> 1, 2
    h_states = 3'b110;
    drive(3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick("genh_110");
    chk("genh_110.head", addr_fetch, 2'b01);
    drive(3'b011, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      en_fetch = ~empty_fifo;
      tick("fetchh");
    end

    // v=000: nothing queued, pops ignored
    v_states = 3'b000;
    drive(3'b101, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick("genv_000");
    drive(3'b010, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) tick("fetch_empty");

    // v=111 with en dropped after the first scan step -> 0,1,2
    v_states = 3'b111;
    drive(3'b101, 1'b1, 1'b0);
    tick("genv_111.first");
    en = 1'b0;
    for (int i = 0; i < 2; i++) tick("genv_111.hold");
    chk("genv_111.hold_head", addr_fetch, 2'b00);
    en = 1'b1;
    for (int i = 0; i < 3; i++) tick("genv_111.resume");
    drive(3'b010, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick("fetch_111");
      if (i == 0) chk("fetch_111.second", addr_fetch, 2'b01);
    end

    // Reset after one pop in FETCH_V: outputs clear without a clock edge
    v_states = 3'b101;
    drive(3'b101, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick("genv_pre_rst");
    drive(3'b010, 1'b1, 1'b1);
    tick("fetch_pre_rst");
    chk("fetch_pre_rst.head", addr_fetch, 2'b10);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst.addr", addr_fetch, 2'b00);
    chk("async_rst.empty", {1'b0, empty_fifo}, 2'b01);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) tick("post_rst_fetch");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0: statesignal = 3'b000;
        1: statesignal = 3'b001;
        2: statesignal = 3'b101;
        3: statesignal = 3'b010;
        4: statesignal = 3'b111;
        5: statesignal = 3'b011;
        6: statesignal = 3'b100;
        default: statesignal = 3'b110;
      endcase
      en       = ($urandom_range(0, 5) != 0);
      en_fetch = $urandom_range(0, 1) == 1;
      v_states = 3'($urandom_range(0, 7));
      h_states = 3'($urandom_range(0, 7));
      // hold the phase a few cycles so scans and drains happen
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
